ps2_scancode_fifo: RTL and testbench

- Sits directly downstream of the PS/2 byte decoder; consumes its raw received bytes.
- Folds Set-2 prefix sequences (E0, F0, E1 Pause) into single key events of the form {extended, break, code}.
- Filters keyboard status bytes.
- Buffers events in a small first-word-fall-through FIFO that the 68k bus interface pops, with interrupt and overflow status.

---
 rtl/ps2_scancode_fifo_if.sv | 28 ++
 rtl/ps2_scancode_fifo.sv | 163 ++++++++++++++++
 tb/tb_ps2_scancode_fifo.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_scancode_fifo_if.sv
// Byte-in / event-out bundle between the PS/2 decoder, the scancode FIFO and the 68k bus side.
interface ps2_scancode_fifo_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          rd_en;
  logic          clr_status;
  logic [9:0]    rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          irq;
  logic          overflow;
  logic          err;

  modport master (
    output byte_valid, byte_data, rd_en, clr_status,
    input  rd_data, empty, full, count, irq, overflow, err
  );

  modport slave (
    input  byte_valid, byte_data, rd_en, clr_status,
    output rd_data, empty, full, count, irq, overflow, err
  );
endinterface

// File: rtl/ps2_scancode_fifo.sv
// Folds PS/2 Set-2 prefix sequences into {ext, brk, code} events and queues them in a FWFT FIFO.
// Entries are visible the cycle after the accepting edge; full FIFO drops new events and flags overflow.
module ps2_scancode_fifo #(
  parameter int DEPTH     = 8,
  parameter int PAUSE_LEN = 7
) (
  input  logic                clk,
  input  logic                reset,
  ps2_scancode_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(PAUSE_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic            vld_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;
  logic [9:0]      mem_q [DEPTH];

  logic            accept;
  logic            is_err_byte;
  logic            is_status_byte;
  logic            push;
  logic [9:0]      push_dat;
  logic            set_err;
  logic            empty, full;
  logic            do_push, do_pop, drop;
  logic [7:0]      b;

  assign b              = bus.byte_data;
  assign accept         = bus.byte_valid & ~vld_q;
  assign is_err_byte    = (b == 8'h00) || (b == 8'hFF);
  assign is_status_byte = (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFE);

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    push     = 1'b0;
    push_dat = '0;
    set_err  = 1'b0;
    if (accept) begin
      unique case (state_q)
        S_IDLE: begin
          if (b == 8'hE0) begin
            state_d = S_EXT;
          end else if (b == 8'hF0) begin
            state_d = S_BRK;
          end else if (b == 8'hE1) begin
            state_d = S_PAUSE;
            pcnt_d  = PW'(PAUSE_LEN);
          end else if (is_status_byte) begin
            state_d = S_IDLE;
          end else if (is_err_byte) begin
            set_err = 1'b1;
          end else begin
            push     = 1'b1;
            push_dat = {2'b00, b};
          end
        end
        S_EXT: begin
          state_d = S_IDLE;
          if (b == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else if (b == 8'h12) begin
            state_d = S_IDLE;
          end else if (is_err_byte) begin
            set_err = 1'b1;
          end else begin
            push     = 1'b1;
            push_dat = {2'b10, b};
          end
        end
        S_BRK: begin
          state_d = S_IDLE;
          if (is_err_byte) begin
            set_err = 1'b1;
          end else begin
            push     = 1'b1;
            push_dat = {2'b01, b};
          end
        end
        S_EXT_BRK: begin
          state_d = S_IDLE;
          if (b == 8'h12) begin
            state_d = S_IDLE;
          end else if (is_err_byte) begin
            set_err = 1'b1;
          end else begin
            push     = 1'b1;
            push_dat = {2'b11, b};
          end
        end
        S_PAUSE: begin
          // Pause payload content is irrelevant; only the byte count matters.
          pcnt_d = pcnt_q - PW'(1);
          if (pcnt_q <= PW'(1)) begin
            pcnt_d   = '0;
            state_d  = S_IDLE;
            push     = 1'b1;
            push_dat = {2'b10, 8'h77};
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = bus.rd_en & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);
  assign ovf_d   = drop    | (ovf_q & ~bus.clr_status);
  assign err_d   = set_err | (err_q & ~bus.clr_status);

  always_ff @(posedge clk) begin
    if (reset) begin
      // Held high so a byte_valid level that straddles reset is not taken as a new byte.
      vld_q    <= 1'b1;
      state_q  <= S_IDLE;
      pcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      vld_q    <= bus.byte_valid;
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= push_dat;
  end

  assign bus.rd_data  = empty ? 10'd0 : mem_q[rd_ptr_q];
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count_q;
  assign bus.irq      = ~empty;
  assign bus.overflow = ovf_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Directed bench for ps2_scancode_fifo: expected events queued at stimulus time, popped by a monitor.
module tb_ps2_scancode_fifo;
  logic clk   = 1'b0;
  logic reset = 1'b1;

  ps2_scancode_fifo_if #(.DEPTH(8)) bus ();

  ps2_scancode_fifo #(.DEPTH(8), .PAUSE_LEN(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic       rd_en_r  = 1'b0;
  bit         drain_en = 1'b0;
  bit         pop_once = 1'b0;
  logic [9:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  assign bus.rd_en = rd_en_r;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: compares the head against the scoreboard and pops it on the next edge.
  always @(negedge clk) begin
    rd_en_r = 1'b0;
    if (!reset && (drain_en || pop_once) && !bus.empty) begin
      pop_once = 1'b0;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL entry: got 0x%0h, expected no entry", bus.rd_data);
      end else begin
        check("entry", int'(bus.rd_data), int'(exp_q.pop_front()));
      end
      rd_en_r = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit pop = 1'b0);
    tick();
    if (pop) pop_once = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = v;
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic drain(input int cycles);
    drain_en = 1'b1;
    repeat (cycles) tick();
    drain_en = 1'b0;
  endtask

  logic [7:0] pause_seq [7] = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.clr_status = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    check("rst_empty", int'(bus.empty), 1);
    check("rst_full", int'(bus.full), 0);
    check("rst_count", int'(bus.count), 0);
    check("rst_irq", int'(bus.irq), 0);
    check("rst_rd_data", int'(bus.rd_data), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    check("rst_err", int'(bus.err), 0);

    // Single make code, visible one cycle after acceptance.
    exp_q.push_back(10'h01C);
    send_byte(8'h1C);
    check("t1_empty", int'(bus.empty), 0);
    check("t1_irq", int'(bus.irq), 1);
    check("t1_count", int'(bus.count), 1);
    check("t1_head", int'(bus.rd_data), 10'h01C);
    drain(3);
    check("t1_empty_after_pop", int'(bus.empty), 1);
    check("t1_rd_data_empty", int'(bus.rd_data), 0);

    // Prefix folding and status filtering.
    drain_en = 1'b1;
    exp_q.push_back(10'h374);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    exp_q.push_back(10'h11C);
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hAA);
    repeat (4) tick();
    drain_en = 1'b0;
    check("t2_count", int'(bus.count), 0);

    // Held byte_valid level is a single acceptance; reset while held accepts nothing.
    tick();
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h1C;
    repeat (3) tick();
    check("t3_held_count", int'(bus.count), 1);
    check("t3_held_head", int'(bus.rd_data), 10'h01C);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (2) tick();
    check("t3_post_reset_count", int'(bus.count), 0);
    check("t3_post_reset_empty", int'(bus.empty), 1);
    bus.byte_valid = 1'b0;

    // Pause: one event, only after the 7th trailing byte.
    send_byte(8'hE1);
    for (int i = 0; i < 6; i++) send_byte(pause_seq[i]);
    check("t4_pause_pending", int'(bus.count), 0);
    exp_q.push_back(10'h277);
    send_byte(pause_seq[6]);
    check("t4_pause_count", int'(bus.count), 1);
    exp_q.push_back(10'h01C);
    send_byte(8'h1C);
    drain(4);

    // Overflow with DEPTH=8, then simultaneous push/pop while full.
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back(10'h015 + 10'(i));
      send_byte(8'h15 + 8'(i));
    end
    check("t5_full", int'(bus.full), 1);
    check("t5_count", int'(bus.count), 8);
    check("t5_overflow", int'(bus.overflow), 1);
    check("t5_head", int'(bus.rd_data), 10'h015);
    exp_q.push_back(10'h030);
    send_byte(8'h30, 1'b1);
    check("t5_pushpop_count", int'(bus.count), 8);
    check("t5_pushpop_overflow", int'(bus.overflow), 1);
    check("t5_pushpop_head", int'(bus.rd_data), 10'h016);
    tick();
    bus.clr_status = 1'b1;
    tick();
    bus.clr_status = 1'b0;
    check("t5_clr_overflow", int'(bus.overflow), 0);
    drain(12);

    // Error bytes set err, produce no entry, and return the parser to IDLE.
    send_byte(8'hFF);
    send_byte(8'hE0);
    send_byte(8'h00);
    check("t6_err", int'(bus.err), 1);
    check("t6_count", int'(bus.count), 0);
    exp_q.push_back(10'h01C);
    send_byte(8'h1C);
    check("t6_idle_head", int'(bus.rd_data), 10'h01C);
    tick();
    bus.clr_status = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h00;
    tick();
    bus.clr_status = 1'b0;
    bus.byte_valid = 1'b0;
    check("t6_set_beats_clr", int'(bus.err), 1);
    tick();
    bus.clr_status = 1'b1;
    tick();
    bus.clr_status = 1'b0;
    check("t6_clr_err", int'(bus.err), 0);

    drain_en = 1'b1;
    for (int i = 0; i < 50 && (exp_q.size() != 0 || !bus.empty); i++) tick();
    drain_en = 1'b0;
    check("final_scoreboard_left", exp_q.size(), 0);
    check("final_empty", int'(bus.empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
